// File: rtl/ovr_dff_bank.sv
// Register bank with per-bit clear/preset overrides, an optional whole-word output force
// (enabled by defining OVR_DFF_BANK_FORCE_EN), and a saturating override-release counter.
module ovr_dff_bank #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic [WIDTH-1:0] clear_n,
    input  logic [WIDTH-1:0] preset_n,
    input  logic             force_en,
    input  logic [WIDTH-1:0] force_val,
    output logic [WIDTH-1:0] q,
    output logic [1:0]       mode,
    output logic [CNT_W-1:0] rel_count
);

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_ASSIGN = 2'd1,
        MODE_FORCE  = 2'd2
    } mode_e;

    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] ovr_q, ovr_d;
    logic [CNT_W-1:0] cnt_q;
    mode_e            mode_q;
    logic             release_evt;
    logic             force_act;

`ifdef OVR_DFF_BANK_FORCE_EN
    assign force_act = force_en;
`else
    logic unused_force;
    assign force_act    = 1'b0;
    assign unused_force = ^{force_en, force_val};
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        s_d   = s_q;
        ovr_d = ~(clear_n & preset_n);
        for (int i = 0; i < WIDTH; i++) begin
            if (!clear_n[i])       s_d[i] = 1'b0;
            else if (!preset_n[i]) s_d[i] = 1'b1;
            else if (load)         s_d[i] = d[i];
        end
        // Several bits releasing on the same edge still count as one event.
        release_evt = |(ovr_q & ~ovr_d);
        q_d         = force_act ? force_val : s_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_q    <= '0;
            q_q    <= '0;
            ovr_q  <= '0;
            cnt_q  <= '0;
            mode_q <= MODE_NORMAL;
        end else begin
            s_q   <= s_d;
            q_q   <= q_d;
            ovr_q <= ovr_d;
            if (release_evt && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + CNT_W'(1);
            if (force_act)   mode_q <= MODE_FORCE;
            else if (|ovr_d) mode_q <= MODE_ASSIGN;
            else             mode_q <= MODE_NORMAL;
        end
    end

    assign q         = q_q;
    assign mode      = mode_q;
    assign rel_count = cnt_q;

endmodule

// File: doc/ovr_dff_bank.md
OVR_DFF_BANK -- requirements
Module: ovr_dff_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, number of register bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, width of the release-event counter.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port d, input, WIDTH, load data.
REQ-006 The block SHALL have port load, input, 1, load d into the released bits.
REQ-007 The block SHALL have port clear_n, input, WIDTH, per-bit active-low hold-at-0 override.
REQ-008 The block SHALL have port preset_n, input, WIDTH, per-bit active-low hold-at-1 override.
REQ-009 The block SHALL have port force_en, input, 1, whole-word force request.
REQ-010 The block SHALL have port force_val, input, WIDTH, forced output value.
REQ-011 The block SHALL have port q, output, WIDTH, registered output.
REQ-012 The block SHALL have port mode, output, 2, status: 0 NORMAL, 1 ASSIGN, 2 FORCE.
REQ-013 The block SHALL have port rel_count, output, CNT_W, saturating count of override-release events.

Function
REQ-014 The block SHALL hold internal state s[WIDTH]; every input takes effect at the next clock edge, so output latency is 1 cycle.
REQ-015 Per bit i, with priority clear over preset over load: clear_n[i]=0 gives s[i]<=0; else preset_n[i]=0 gives s[i]<=1; else load=1 gives s[i]<=d[i]; else s[i] holds.
REQ-016 When a bit's override is removed, it SHALL retain its override value until the next load, with no snap-back to pre-override data.
REQ-017 When force_en=1, q SHALL be set to force_val at the next edge; s SHALL keep updating per REQ-015 while forced.
REQ-018 When force_en=0, q SHALL be set to the next value of s, so on force release q equals current s at the next edge, including any active override.
REQ-019 The mode FSM SHALL go to FORCE when force_en=1, else ASSIGN when any clear_n or preset_n bit is 0, else NORMAL; it is evaluated every edge, any state can reach any state, and priority is FORCE > ASSIGN > NORMAL.
REQ-020 A release event SHALL be one edge where any bit transitions from overridden to released (per-bit registered override flags); simultaneous releases of multiple bits count as 1.
REQ-021 rel_count SHALL increment by 1 per release event and saturate at 2^CNT_W-1 with no wrap.
REQ-022 When clear_n[i]=0 and preset_n[i]=0 together, clear SHALL win and the bit counts as overridden.

Reset
REQ-023 When reset=1 at an edge, s, q, the override flags and rel_count SHALL be 0 and mode SHALL be NORMAL, overriding force, clear, preset and load.
REQ-024 Reset asserted mid-override or mid-force SHALL NOT generate a release event.
REQ-025 On the first edge after reset deasserts, the block SHALL evaluate inputs normally; overrides still held then SHALL be registered as overrides.

Configuration
REQ-026 With macro OVR_DFF_BANK_FORCE_EN defined, force_en and force_val SHALL behave per REQ-017/018.
REQ-027 Without OVR_DFF_BANK_FORCE_EN, force_en and force_val SHALL remain ports but be ignored: q always follows s and mode never equals 2.

Verification
REQ-028 Load test: WIDTH=8, load=1, d=8'hA5, all overrides released -> q=8'hA5 one cycle later, mode=0.
REQ-029 Override-and-release test: from q=8'hA5, clear_n=8'hF0 for 3 cycles, then all released with load=0 -> q=8'hA0 while held and still 8'hA0 after release, rel_count=1, mode 1 then 0.
REQ-030 Force test: s=8'h0F, force_en=1, force_val=8'hFF, preset_n=8'h7F -> q=8'hFF, mode=2; force release -> q=8'h8F next edge, mode=1.
REQ-031 Reset and clear-priority test: reset=1 during force with clear active -> q=0, rel_count=0, mode=0, and no count when the override is later released under reset; clear_n[0]=0 with preset_n[0]=0 -> q[0]=0.
REQ-032 Saturation test: CNT_W=2, 5 release events -> rel_count sequence 1,2,3,3,3; build without the macro with force_en=1 -> q follows s, mode never 2.
